// File: rtl/ch_seq_ctrl.sv
// Channel sequencer: a strobe starts one scan that steps the channel index 1..N, one channel
// per clock, then returns to idle index 0. N and the enable mask are captured at scan start.
// A strobe on the last scan cycle restarts the scan back-to-back; any other mid-scan strobe is
// rejected and flagged with a one-cycle overrun pulse.
// Optional feature: define CH_SEQ_OVR_CNT_EN for a saturating overrun event counter.
module ch_seq_ctrl #(
    parameter int unsigned CH_W  = 4,
    parameter int unsigned OVR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 strobe,
    input  logic [CH_W-1:0]      num_ch,
    input  logic [2**CH_W-1:0]   ch_mask,
    input  logic                 ovr_clr,
    output logic [CH_W-1:0]      channel,
    output logic                 ch_valid,
    output logic                 ch_last,
    output logic                 busy,
    output logic                 overrun,
    output logic [OVR_W-1:0]     ovr_count
);

    localparam int unsigned      NumBits = 2**CH_W;
    localparam logic [CH_W-1:0]  ChOne   = CH_W'(1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e                state;
    logic [CH_W-1:0]       n_lat;
    logic [NumBits-1:0]    m_lat;

    logic [CH_W-1:0]       next_ch;
    logic                  is_last;
    logic                  start_scan;
    logic                  ovr_event;

    // Decode the scan position and classify the incoming strobe.
    always_comb begin
        next_ch    = channel + ChOne;
        is_last    = (channel == n_lat);
        // A strobe is accepted from idle or on the final scan cycle (back-to-back restart).
        start_scan = strobe && (num_ch != '0) && ((state == StIdle) || is_last);
        ovr_event  = strobe && (state == StScan) && !is_last;
    end

    // Scan FSM with registered outputs; n_lat/m_lat only change on an accepted strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            n_lat    <= '0;
            m_lat    <= '0;
            channel  <= '0;
            ch_valid <= 1'b0;
            ch_last  <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= ovr_event;
            if (start_scan) begin
                state    <= StScan;
                n_lat    <= num_ch;
                m_lat    <= ch_mask;
                channel  <= ChOne;
                ch_valid <= ch_mask[1];
                ch_last  <= (num_ch == ChOne);
                busy     <= 1'b1;
            end else if ((state == StScan) && !is_last) begin
                // next_ch never wraps: is_last stops the scan at n_lat <= all-ones.
                channel  <= next_ch;
                ch_valid <= m_lat[next_ch];
                ch_last  <= (next_ch == n_lat);
                busy     <= 1'b1;
            end else begin
                state    <= StIdle;
                channel  <= '0;
                ch_valid <= 1'b0;
                ch_last  <= 1'b0;
                busy     <= 1'b0;
            end
        end
    end

`ifdef CH_SEQ_OVR_CNT_EN
    // Saturating count of rejected strobes; clear has priority over a same-cycle event.
    always_ff @(posedge clk) begin
        if (reset || ovr_clr) begin
            ovr_count <= '0;
        end else if (ovr_event && (ovr_count != '1)) begin
            ovr_count <= ovr_count + OVR_W'(1);
        end
    end
`else
    logic unused_ovr;
    assign unused_ovr = ovr_clr ^ ovr_event;
    assign ovr_count  = '0;
`endif

endmodule

// File: tb/tb_ch_seq_ctrl.sv
// Directed self-checking bench for ch_seq_ctrl. Runs with OVR_W=2 so counter saturation is
// reachable in a few events; counter expectations follow CH_SEQ_OVR_CNT_EN.
module tb_ch_seq_ctrl;

    localparam int unsigned CH_W  = 4;
    localparam int unsigned OVR_W = 2;

`ifdef CH_SEQ_OVR_CNT_EN
    localparam bit OvrEn = 1'b1;
`else
    localparam bit OvrEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              strobe;
    logic [CH_W-1:0]   num_ch;
    logic [15:0]       ch_mask;
    logic              ovr_clr;
    logic [CH_W-1:0]   channel;
    logic              ch_valid;
    logic              ch_last;
    logic              busy;
    logic              overrun;
    logic [OVR_W-1:0]  ovr_count;

    int errors = 0;
    int checks = 0;

    ch_seq_ctrl #(
        .CH_W  (CH_W),
        .OVR_W (OVR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .strobe    (strobe),
        .num_ch    (num_ch),
        .ch_mask   (ch_mask),
        .ovr_clr   (ovr_clr),
        .channel   (channel),
        .ch_valid  (ch_valid),
        .ch_last   (ch_last),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_count (ovr_count)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset = 1'b1; strobe = 1'b0; num_ch = '0; ch_mask = '0; ovr_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        got = {channel, ch_valid, ch_last, busy, overrun};
        if (got !== 8'h00 || ovr_count !== '0) begin
            errors++;
            $display("FAIL reset: outputs=%h cnt=%0d, required 00 cnt=0", got, ovr_count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] got, exp;
        num_ch = 4'd3; ch_mask = 16'hFFFF; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {(i < 3) ? 4'(i + 1) : 4'd0, i < 3, i == 2, i < 3, 1'b0};
            got = {channel, ch_valid, ch_last, busy, overrun};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic step %0d: {ch,vld,last,busy,ovr}=%h, required %h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_mask();
        logic [3:0] exp_vld = 4'b1010;  // bit i -> channel i+1; mask 0x0014 enables 2 and 4
        num_ch = 4'd4; ch_mask = 16'h0014; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (channel !== 4'(i + 1) || ch_valid !== exp_vld[i]) begin
                errors++;
                $display("FAIL mask ch%0d: channel=%0d vld=%b, required channel=%0d vld=%b",
                         i + 1, channel, ch_valid, i + 1, exp_vld[i]);
            end
            tick();
        end
        checks++;
        if (channel !== 4'd0 || ch_valid !== 1'b0) begin
            errors++;
            $display("FAIL mask end: channel=%0d vld=%b, required 0 0", channel, ch_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ch  [5] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd0};
        logic       exp_vld [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_bsy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        num_ch = 4'd2; ch_mask = 16'h0004; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (channel !== exp_ch[i] || ch_valid !== exp_vld[i] || busy !== exp_bsy[i] ||
                overrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b step %0d: ch=%0d vld=%b busy=%b ovr=%b, required %0d %b %b 0",
                         i, channel, ch_valid, busy, overrun, exp_ch[i], exp_vld[i], exp_bsy[i]);
            end
            // Restart during the channel=2 cycle with a new mask.
            if (i == 1) begin
                strobe = 1'b1; ch_mask = 16'h0002;
            end else begin
                strobe = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_overrun();
        logic [3:0] exp_ch  [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        logic       exp_ovr [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        num_ch = 4'd5; ch_mask = 16'hFFFF; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (channel !== exp_ch[i] || overrun !== exp_ovr[i]) begin
                errors++;
                $display("FAIL overrun step %0d: ch=%0d ovr=%b, required %0d %b",
                         i, channel, overrun, exp_ch[i], exp_ovr[i]);
            end
            if (i == 1) begin
                checks++;
                if (ovr_count !== (OvrEn ? 2'd1 : 2'd0)) begin
                    errors++;
                    $display("FAIL overrun count: got %0d, required %0d", ovr_count, OvrEn);
                end
            end
            strobe = (i == 0);
            tick();
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++;
        if (ovr_count !== '0) begin
            errors++;
            $display("FAIL overrun clear: got %0d, required 0", ovr_count);
        end
    endtask

    task automatic test_ignore();
        num_ch = 4'd0; ch_mask = 16'hFFFF; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        checks++;
        if (channel !== 4'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL zero-N strobe: ch=%0d busy=%b ovr=%b, required 0 0 0",
                     channel, busy, overrun);
        end
        num_ch = 4'd3; strobe = 1'b1;
        tick();
        strobe = 1'b0; num_ch = 4'd7;
        tick();
        tick();
        checks++;
        if (channel !== 4'd3 || ch_last !== 1'b1) begin
            errors++;
            $display("FAIL latched N: ch=%0d last=%b, required 3 1", channel, ch_last);
        end
        // Last-cycle strobe with N=0 ends the scan without overrun.
        num_ch = 4'd0; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        checks++;
        if (channel !== 4'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL last-cycle zero-N: ch=%0d busy=%b ovr=%b, required 0 0 0",
                     channel, busy, overrun);
        end
    endtask

    task automatic test_max_channels();
        num_ch = 4'd15; ch_mask = 16'h8000; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (channel !== 4'(i % 16) || ch_valid !== (i == 15) || ch_last !== (i == 15)) begin
                errors++;
                $display("FAIL max N step %0d: ch=%0d vld=%b last=%b, required %0d %b %b",
                         i, channel, ch_valid, ch_last, i % 16, i == 15, i == 15);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] got;
        num_ch = 4'd6; ch_mask = 16'hFFFF; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        checks++;
        if (channel !== 4'd2) begin
            errors++;
            $display("FAIL pre-reset: ch=%0d, required 2", channel);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got = {channel, ch_valid, ch_last, busy, overrun};
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL mid-scan reset: outputs=%h, required 00", got);
        end
        tick();
        checks++;
        if (channel !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL scan abandoned: ch=%0d busy=%b, required 0 0", channel, busy);
        end
    endtask

    task automatic test_saturation();
        logic [OVR_W-1:0] exp;
        num_ch = 4'd15; ch_mask = 16'hFFFF; strobe = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            exp = OvrEn ? ((i + 1 > 3) ? 2'd3 : 2'(i + 1)) : 2'd0;
            checks++;
            if (overrun !== 1'b1 || ovr_count !== exp) begin
                errors++;
                $display("FAIL saturation event %0d: ovr=%b cnt=%0d, required 1 %0d",
                         i, overrun, ovr_count, exp);
            end
            tick();
        end
        // Clear and event in the same cycle: clear wins.
        strobe = 1'b1; ovr_clr = 1'b1;
        tick();
        strobe = 1'b0; ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1 || ovr_count !== '0) begin
            errors++;
            $display("FAIL clear priority: ovr=%b cnt=%0d, required 1 0", overrun, ovr_count);
        end
        for (int i = 0; i < 20 && busy; i++) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_back_to_back();
        test_overrun();
        test_ignore();
        test_max_channels();
        test_reset_mid_scan();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
